// File: rtl/clk_btn_front_end.sv
// Clock divider and two-button debouncer that feed the 8-bit up/down LED counter stage.
// Optional feature macro RATE_SEL_EN adds a 2-bit Rate input that scales the divided clock x1/x2/x4/x8.
module clk_btn_front_end #(
    parameter int HALF_PERIOD = 16_666_667,
    parameter int DB_CYCLES   = 1_000_000,
    parameter int CNT_W       = 25,
    parameter int DB_W        = 20
) (
    input  logic       Clk50MHz,
    input  logic       RST_n,
    input  logic       BTN_SS_n,
    input  logic       BTN_UD_n,
`ifdef RATE_SEL_EN
    input  logic [1:0] Rate,
`endif
    output logic       Clk1_5Hz,
    output logic       Tick,
    output logic       SS,
    output logic       UD
);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_PERIOD);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);

    // ---------------- clock divider ----------------
    logic [CNT_W-1:0] r_div_cnt;
    logic             r_clk_div;
    logic             r_tick;
    logic [CNT_W-1:0] w_term;
    logic             w_wrap;

`ifdef RATE_SEL_EN
    logic [CNT_W-1:0] w_half_sel;
    assign w_half_sel = HALF_CNT >> Rate;
    // Clamp so an over-divided half period cannot underflow into a huge terminal count.
    assign w_term = (w_half_sel == '0) ? '0 : w_half_sel - CNT_W'(1);
`else
    assign w_term = HALF_CNT - CNT_W'(1);
`endif

    // >= rather than == so a terminal count lowered below the current count wraps at once.
    assign w_wrap = (r_div_cnt >= w_term);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk50MHz or negedge RST_n) begin
        if (!RST_n) begin
            r_div_cnt <= '0;
            r_clk_div <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= w_wrap & ~r_clk_div;
            if (w_wrap) begin
                r_div_cnt <= '0;
                r_clk_div <= ~r_clk_div;
            end else begin
                r_div_cnt <= r_div_cnt + CNT_W'(1);
            end
        end
    end

    // ---------------- button synchronise / debounce ----------------
    // Bit 0 is the run/hold button, bit 1 the up/down button.
    logic [1:0]            w_btn_raw;
    logic [1:0]            r_sync1;
    logic [1:0]            r_sync2;
    logic [1:0]            r_db_lvl;
    logic [1:0]            r_press;
    logic [1:0][DB_W-1:0]  r_db_cnt;
    logic [1:0]            w_differ;
    logic [1:0]            w_accept;

    assign w_btn_raw = {BTN_UD_n, BTN_SS_n};
    assign w_differ  = r_sync2 ^ r_db_lvl;

    // NOTE: the default assignment before the loop keeps this block free of inferred latches.
    always_comb begin
        w_accept = '0;
        for (int b = 0; b < 2; b++) begin
            w_accept[b] = w_differ[b] && (r_db_cnt[b] == DB_LAST);
        end
    end

    // NOTE: the small counter array is reset explicitly; it is control state, not a RAM.
    always_ff @(posedge Clk50MHz or negedge RST_n) begin
        if (!RST_n) begin
            r_sync1  <= '1;
            r_sync2  <= '1;
            r_db_lvl <= '1;
            r_db_cnt <= '0;
            r_press  <= '0;
        end else begin
            r_sync1  <= w_btn_raw;
            r_sync2  <= r_sync1;
            r_db_lvl <= (r_db_lvl & ~w_accept) | (r_sync2 & w_accept);
            // Only an accepted move to the pressed (low) level counts as a press.
            r_press  <= w_accept & ~r_sync2;
            for (int b = 0; b < 2; b++) begin
                if (!w_differ[b] || w_accept[b]) begin
                    r_db_cnt[b] <= '0;
                end else begin
                    r_db_cnt[b] <= r_db_cnt[b] + DB_W'(1);
                end
            end
        end
    end

    // ---------------- run/hold and direction levels ----------------
    logic r_ss;
    logic r_ud;

    always_ff @(posedge Clk50MHz or negedge RST_n) begin
        if (!RST_n) begin
            r_ss <= 1'b0;
            r_ud <= 1'b0;
        end else begin
            r_ss <= r_ss ^ r_press[0];
            r_ud <= r_ud ^ r_press[1];
        end
    end

    assign Clk1_5Hz = r_clk_div;
    assign Tick     = r_tick;
    assign SS       = r_ss;
    assign UD       = r_ud;

endmodule

// File: tb/tb_clk_btn_front_end.sv
// Self-checking bench for clk_btn_front_end with HALF_PERIOD=4, DB_CYCLES=5.
// Outputs are compared against a cycle-level behavioural model built from the divide/debounce rules.
module tb_clk_btn_front_end;

    localparam int H  = 4;
    localparam int DB = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_ss_n;
    logic btn_ud_n;
`ifdef RATE_SEL_EN
    logic [1:0] rate;
`endif
    logic clk_1_5hz;
    logic tick;
    logic ss;
    logic ud;

    int n_checks;
    int n_fail;

    // behavioural model state
    int       m_n;
    bit       m_clk, m_tick, m_ss, m_ud;
    bit [1:0] m_p1, m_p2, m_lvl, m_pend;
    int       m_run [2];

    clk_btn_front_end #(
        .HALF_PERIOD (H),
        .DB_CYCLES   (DB),
        .CNT_W       (25),
        .DB_W        (20)
    ) dut (
        .Clk50MHz (clk),
        .RST_n    (rst_n),
        .BTN_SS_n (btn_ss_n),
        .BTN_UD_n (btn_ud_n),
`ifdef RATE_SEL_EN
        .Rate     (rate),
`endif
        .Clk1_5Hz (clk_1_5hz),
        .Tick     (tick),
        .SS       (ss),
        .UD       (ud)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_n    = 0;
        m_clk  = 0;
        m_tick = 0;
        m_ss   = 0;
        m_ud   = 0;
        m_p1   = 2'b11;
        m_p2   = 2'b11;
        m_lvl  = 2'b11;
        m_pend = 2'b00;
        m_run[0] = 0;
        m_run[1] = 0;
    endtask

    // One rising edge: the divided clock follows from the edge count since reset;
    // a button level is accepted after DB consecutive synchronised samples that
    // differ from it, and an accepted press flips the output one edge later.
    task automatic model_edge();
        bit [1:0] raw;
        bit [1:0] samp;
        raw  = {btn_ud_n, btn_ss_n};
        m_n++;
        m_clk  = ((m_n / H) % 2) == 1;
        m_tick = (m_n % (2 * H)) == H;
        m_ss   = m_ss ^ m_pend[0];
        m_ud   = m_ud ^ m_pend[1];
        m_pend = 2'b00;
        samp   = m_p2;
        for (int b = 0; b < 2; b++) begin
            if (samp[b] != m_lvl[b]) m_run[b]++;
            else                     m_run[b] = 0;
            if (m_run[b] == DB) begin
                m_lvl[b]  = samp[b];
                m_run[b]  = 0;
                m_pend[b] = (samp[b] == 1'b0);
            end
        end
        m_p2 = m_p1;
        m_p1 = raw;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        btn_ss_n = 1'b1;
        btn_ud_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({clk_1_5hz, tick, ss, ud} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state: clk/tick/ss/ud got %b expected 0000", {clk_1_5hz, tick, ss, ud});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_divider();
        int ticks;
        ticks = 0;
        for (int i = 1; i <= 24; i++) begin
            step();
            n_checks++;
            if ({clk_1_5hz, tick, ss, ud} !== {m_clk, m_tick, m_ss, m_ud}) begin
                n_fail++;
                $display("FAIL divider step %0d: clk/tick/ss/ud got %b expected %b",
                         i, {clk_1_5hz, tick, ss, ud}, {m_clk, m_tick, m_ss, m_ud});
            end
            if (tick === 1'b1) ticks++;
        end
        n_checks++;
        if (ticks != 3) begin
            n_fail++;
            $display("FAIL divider_tick_count: got %0d expected 3", ticks);
        end
    endtask

    task automatic test_ss_press();
        int toggles;
        int at;
        logic prev;
        toggles  = 0;
        at       = -1;
        prev     = ss;
        btn_ss_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            n_checks++;
            if ({clk_1_5hz, tick, ss, ud} !== {m_clk, m_tick, m_ss, m_ud}) begin
                n_fail++;
                $display("FAIL ss_hold step %0d: clk/tick/ss/ud got %b expected %b",
                         i, {clk_1_5hz, tick, ss, ud}, {m_clk, m_tick, m_ss, m_ud});
            end
            if (ss !== prev) begin
                toggles++;
                if (at < 0) at = i;
            end
            prev = ss;
        end
        n_checks++;
        if (toggles != 1 || at != 2 + DB + 1) begin
            n_fail++;
            $display("FAIL ss_latency: toggles %0d at step %0d, expected 1 at step %0d", toggles, at, 2 + DB + 1);
        end
        btn_ss_n = 1'b1;
        repeat (10) begin
            step();
            n_checks++;
            if ({clk_1_5hz, tick, ss, ud} !== {m_clk, m_tick, m_ss, m_ud}) begin
                n_fail++;
                $display("FAIL ss_release: clk/tick/ss/ud got %b expected %b",
                         {clk_1_5hz, tick, ss, ud}, {m_clk, m_tick, m_ss, m_ud});
            end
        end
        btn_ss_n = 1'b0;
        repeat (12) begin
            step();
            n_checks++;
            if ({clk_1_5hz, tick, ss, ud} !== {m_clk, m_tick, m_ss, m_ud}) begin
                n_fail++;
                $display("FAIL ss_second_press: clk/tick/ss/ud got %b expected %b",
                         {clk_1_5hz, tick, ss, ud}, {m_clk, m_tick, m_ss, m_ud});
            end
        end
        n_checks++;
        if (ss !== 1'b0) begin
            n_fail++;
            $display("FAIL ss_second_toggle: got %b expected 0", ss);
        end
        btn_ss_n = 1'b1;
        repeat (8) step();
    endtask

    task automatic test_ud_bounce();
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) begin
                btn_ud_n = (i == 3);
                step();
                n_checks++;
                if ({clk_1_5hz, tick, ss, ud} !== {m_clk, m_tick, m_ss, m_ud}) begin
                    n_fail++;
                    $display("FAIL ud_bounce r%0d i%0d: clk/tick/ss/ud got %b expected %b",
                             r, i, {clk_1_5hz, tick, ss, ud}, {m_clk, m_tick, m_ss, m_ud});
                end
            end
        end
        n_checks++;
        if (ud !== 1'b0) begin
            n_fail++;
            $display("FAIL ud_bounce_hold: got %b expected 0", ud);
        end
        btn_ud_n = 1'b0;
        repeat (10) begin
            step();
            n_checks++;
            if ({clk_1_5hz, tick, ss, ud} !== {m_clk, m_tick, m_ss, m_ud}) begin
                n_fail++;
                $display("FAIL ud_steady: clk/tick/ss/ud got %b expected %b",
                         {clk_1_5hz, tick, ss, ud}, {m_clk, m_tick, m_ss, m_ud});
            end
        end
        n_checks++;
        if (ud !== 1'b1) begin
            n_fail++;
            $display("FAIL ud_steady_toggle: got %b expected 1", ud);
        end
        btn_ud_n = 1'b1;
        repeat (8) step();
    endtask

    task automatic test_both();
        int at_ss;
        int at_ud;
        logic p_ss;
        logic p_ud;
        at_ss = -1;
        at_ud = -1;
        p_ss  = ss;
        p_ud  = ud;
        btn_ss_n = 1'b0;
        btn_ud_n = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            n_checks++;
            if ({clk_1_5hz, tick, ss, ud} !== {m_clk, m_tick, m_ss, m_ud}) begin
                n_fail++;
                $display("FAIL both step %0d: clk/tick/ss/ud got %b expected %b",
                         i, {clk_1_5hz, tick, ss, ud}, {m_clk, m_tick, m_ss, m_ud});
            end
            if (ss !== p_ss && at_ss < 0) at_ss = i;
            if (ud !== p_ud && at_ud < 0) at_ud = i;
        end
        n_checks++;
        if (at_ss != 2 + DB + 1 || at_ud != 2 + DB + 1) begin
            n_fail++;
            $display("FAIL both_same_cycle: ss at %0d ud at %0d expected both at %0d", at_ss, at_ud, 2 + DB + 1);
        end
        btn_ss_n = 1'b1;
        btn_ud_n = 1'b1;
        repeat (8) step();
    endtask

    task automatic test_random();
        int rem [2];
        rem[0] = $urandom_range(1, 9);
        rem[1] = $urandom_range(1, 9);
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < 2; b++) begin
                rem[b]--;
                if (rem[b] <= 0) begin
                    if (b == 0) btn_ss_n = ~btn_ss_n;
                    else        btn_ud_n = ~btn_ud_n;
                    rem[b] = $urandom_range(1, 9);
                end
            end
            step();
            n_checks++;
            if ({clk_1_5hz, tick, ss, ud} !== {m_clk, m_tick, m_ss, m_ud}) begin
                n_fail++;
                $display("FAIL random step %0d: clk/tick/ss/ud got %b expected %b",
                         i, {clk_1_5hz, tick, ss, ud}, {m_clk, m_tick, m_ss, m_ud});
            end
        end
        btn_ss_n = 1'b1;
        btn_ud_n = 1'b1;
        repeat (8) step();
    endtask

    task automatic test_reset_mid();
        int guard;
        btn_ss_n = 1'b0;
        repeat (4) step();
        guard = 0;
        while (!m_tick && guard < 16) begin
            step();
            guard++;
        end
        n_checks++;
        if ({clk_1_5hz, tick} !== {m_clk, m_tick} || !m_tick) begin
            n_fail++;
            $display("FAIL reset_mid_setup: clk/tick got %b expected 11", {clk_1_5hz, tick});
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({clk_1_5hz, tick, ss, ud} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_async: clk/tick/ss/ud got %b expected 0000", {clk_1_5hz, tick, ss, ud});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 1; i <= 12; i++) begin
            step();
            n_checks++;
            if ({clk_1_5hz, tick, ss, ud} !== {m_clk, m_tick, m_ss, m_ud}) begin
                n_fail++;
                $display("FAIL reset_mid_restart step %0d: clk/tick/ss/ud got %b expected %b",
                         i, {clk_1_5hz, tick, ss, ud}, {m_clk, m_tick, m_ss, m_ud});
            end
        end
        btn_ss_n = 1'b1;
        repeat (8) step();
    endtask

`ifdef RATE_SEL_EN
    task automatic test_rate();
        logic [5:0] e_clk;
        logic [5:0] e_tick;
        // Rate 0 -> 2 with the counter at 3, then Rate 1.
        rst_n = 1'b0;
        rate  = 2'd0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rate   = 2'd2;
        e_clk  = 6'b101010;
        e_tick = 6'b101010;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({clk_1_5hz, tick} !== {e_clk[5-i], e_tick[5-i]}) begin
                n_fail++;
                $display("FAIL rate_x4 edge %0d: clk/tick got %b expected %b",
                         i, {clk_1_5hz, tick}, {e_clk[5-i], e_tick[5-i]});
            end
        end
        rate   = 2'd1;
        e_clk  = 6'b011001;
        e_tick = 6'b010001;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({clk_1_5hz, tick} !== {e_clk[5-i], e_tick[5-i]}) begin
                n_fail++;
                $display("FAIL rate_x2 edge %0d: clk/tick got %b expected %b",
                         i, {clk_1_5hz, tick}, {e_clk[5-i], e_tick[5-i]});
            end
        end
        // Counter at 2 when the terminal count drops to 1: wrap on the very next edge.
        rst_n = 1'b0;
        rate  = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rate = 2'd1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({clk_1_5hz, tick} !== 2'b11) begin
            n_fail++;
            $display("FAIL rate_overshoot_wrap: clk/tick got %b expected 11", {clk_1_5hz, tick});
        end
        rate = 2'd0;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        btn_ss_n = 1'b1;
        btn_ud_n = 1'b1;
`ifdef RATE_SEL_EN
        rate     = 2'd0;
`endif
        model_reset();
        test_reset();
        test_divider();
        test_ss_press();
        test_ud_bounce();
        test_both();
        test_random();
        test_reset_mid();
`ifdef RATE_SEL_EN
        test_rate();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
